// File: rtl/am_modulator.sv
// AM modulator: triangle carrier from a phase accumulator, amplitude-scaled by an
// audio envelope fed through a one-entry holding register refreshed once per sample period.
module am_modulator #(
  parameter int SAMPLE_DIV = 64,
  parameter int PHASE_W    = 16
) (
  input  logic                clk,
  input  logic                RST,
  input  logic                enable,
  input  logic [PHASE_W-1:0]  phase_inc,
  input  logic [1:0]          mod_depth,
  input  logic signed [7:0]   audio_in,
  input  logic                audio_valid,
  output logic                audio_ready,
  output logic signed [7:0]   rf_out,
  output logic                sample_tick,
  output logic                underrun
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [PHASE_W-1:0] r_phase;
  logic [CNT_W-1:0]   r_count;
  logic signed [7:0]  r_hold;
  logic               r_holdFull;
  logic signed [7:0]  r_active;
  logic               r_underrun;
  logic signed [7:0]  r_carrier;
  logic [8:0]         r_env;
  logic signed [7:0]  r_rf;

  logic               w_handshake;
  logic               w_tick;
  logic [1:0]         w_quad;
  logic signed [7:0]  w_mag;
  logic signed [7:0]  w_carrier;
  logic [1:0]         w_shift;
  logic signed [7:0]  w_shifted;
  logic [8:0]         w_env;
  logic signed [16:0] w_product;

  assign w_handshake = audio_valid && !r_holdFull;
  assign w_tick      = enable && (r_count == LAST);

  assign w_quad = r_phase[PHASE_W-1 -: 2];
  assign w_mag  = $signed({1'b0, r_phase[PHASE_W-3 -: 7]});

  always_comb begin
    w_carrier = w_mag;
    case (w_quad)
      2'd0: w_carrier = w_mag;
      2'd1: w_carrier = 8'sd127 - w_mag;
      2'd2: w_carrier = -w_mag;
      2'd3: w_carrier = w_mag - 8'sd127;
      default: w_carrier = w_mag;
    endcase
  end

  // Depth 3 means no shift, depth 0 means shift by 3, so the shift is just the inverted select.
  assign w_shift   = ~mod_depth;
  assign w_shifted = r_active >>> w_shift;
  assign w_env     = 9'(w_shifted) + 9'd128;
  assign w_product = r_carrier * $signed({1'b0, r_env});

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_phase <= '0;
      r_count <= '0;
    end else if (!enable) begin
      r_phase <= '0;
      r_count <= '0;
    end else begin
      r_phase <= r_phase + phase_inc;
      r_count <= w_tick ? '0 : r_count + 1'b1;
    end
  end

  // Holding refills from the handshake; a tick with nothing held (and nothing arriving) is an underrun.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_hold     <= '0;
      r_holdFull <= 1'b0;
      r_active   <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (w_handshake) begin
        r_hold     <= audio_in;
        r_holdFull <= 1'b1;
      end else if (w_tick && r_holdFull) begin
        r_holdFull <= 1'b0;
      end
      if (w_tick && r_holdFull) begin
        r_active <= r_hold;
      end
      if (w_tick && !r_holdFull && !w_handshake) begin
        r_underrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_carrier <= '0;
      r_env     <= '0;
      r_rf      <= '0;
    end else begin
      r_carrier <= enable ? w_carrier : '0;
      r_env     <= enable ? w_env : '0;
      r_rf      <= 8'(w_product >>> 8);
    end
  end

  assign audio_ready = !r_holdFull;
  assign rf_out      = r_rf;
  assign sample_tick = w_tick;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_am_modulator.sv
// Scoreboard bench for am_modulator: an arithmetic reference model queues the expected
// outputs after every clock edge and an independent monitor pops and compares them.
module tb_am_modulator;

  localparam int DIV = 16;
  localparam int PW  = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                enable = 1'b0;
  logic [PW-1:0]       phaseInc = '0;
  logic [1:0]          modDepth = '0;
  logic [7:0]          audioIn = '0;
  logic                audioValid = 1'b0;
  logic                audioReady;
  logic signed [7:0]   rfOut;
  logic                sampleTick;
  logic                underrun;

  int compared = 0;
  int failed   = 0;

  typedef struct {
    int rf;
    bit tick;
    bit ready;
    bit under;
  } exp_t;

  exp_t expQ[$];

  am_modulator #(.SAMPLE_DIV(DIV), .PHASE_W(PW)) dut (
    .clk(clk),
    .RST(rst),
    .enable(enable),
    .phase_inc(phaseInc),
    .mod_depth(modDepth),
    .audio_in(audioIn),
    .audio_valid(audioValid),
    .audio_ready(audioReady),
    .rf_out(rfOut),
    .sample_tick(sampleTick),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic int floorDiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  // Triangle carrier from the top nine phase bits: quadrant plus position within it.
  function automatic int triangle(input int phase);
    int top, q, m;
    top = phase / (1 << (PW - 9));
    q = top / 128;
    m = top % 128;
    case (q)
      0: return m;
      1: return 127 - m;
      2: return -m;
      default: return -(127 - m);
    endcase
  endfunction

  task automatic checkOutput(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
    end
  endtask

  int mPhase, mCnt, mHold, mActive, mS1c, mS1e, mRf;
  bit mHoldFull, mUnderrun;

  always @(posedge clk) begin
    exp_t e;
    bit hs, tk;
    int nc, ne;
    if (rst) begin
      mPhase = 0; mCnt = 0; mHold = 0; mActive = 0;
      mS1c = 0; mS1e = 0; mRf = 0;
      mHoldFull = 0; mUnderrun = 0;
    end else begin
      hs = audioValid && !mHoldFull;
      tk = enable && (mCnt == DIV - 1);
      mRf = floorDiv(mS1c * mS1e, 256);
      nc = enable ? triangle(mPhase) : 0;
      ne = enable ? 128 + floorDiv(mActive, 1 << (3 - int'(modDepth))) : 0;
      mS1c = nc;
      mS1e = ne;
      if (tk && !mHoldFull && !hs) mUnderrun = 1;
      if (tk && mHoldFull) mActive = mHold;
      if (hs) begin
        mHold = int'($signed(audioIn));
        mHoldFull = 1;
      end else if (tk && mHoldFull) begin
        mHoldFull = 0;
      end
      mPhase = enable ? (mPhase + int'(phaseInc)) % (1 << PW) : 0;
      mCnt = enable ? (mCnt + 1) % DIV : 0;
    end
    e.rf = mRf;
    e.tick = enable && (mCnt == DIV - 1);
    e.ready = !mHoldFull;
    e.under = mUnderrun;
    expQ.push_back(e);
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("rf_out", int'(rfOut), e.rf);
      checkOutput("sample_tick", int'(sampleTick), int'(e.tick));
      checkOutput("audio_ready", int'(audioReady), int'(e.ready));
      checkOutput("underrun", int'(underrun), int'(e.under));
    end
  end

  task automatic applyStimulus(input bit en, input int inc, input int depth,
                               input int ain, input bit av, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      enable     = en;
      phaseInc   = PW'(inc);
      modDepth   = 2'(depth);
      audioIn    = 8'(ain);
      audioValid = av;
    end
  endtask

  task automatic randomStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      enable     = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 31) == 0) phaseInc = PW'($urandom_range(0, 65535));
      modDepth   = 2'($urandom_range(0, 3));
      audioIn    = 8'($urandom_range(0, 255));
      audioValid = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    $display("[TB] am_modulator scoreboard run, SAMPLE_DIV=%0d", DIV);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    applyStimulus(1, 'h0400, 3, 0, 0, 5 * DIV);
    applyStimulus(1, 'h0400, 3, 127, 1, 4 * DIV);
    applyStimulus(1, 'h0400, 3, -128, 1, 4 * DIV);
    for (int d = 0; d < 4; d++) applyStimulus(1, 'h0400, d, 64, 1, 3 * DIV);
    applyStimulus(0, 'h0400, 2, 33, 1, 5);
    applyStimulus(1, 'h0777, 2, -50, 1, 3 * DIV);

    randomStimulus(1500);

    // Fill holding with the carrier running, then hit reset mid-cycle.
    applyStimulus(1, 'h0600, 3, 100, 1, 2 * DIV + 3);
    applyStimulus(1, 'h0600, 3, 0, 0, 6);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_rf_out", int'(rfOut), 0);
    checkOutput("rst_audio_ready", int'(audioReady), 1);
    checkOutput("rst_underrun", int'(underrun), 0);
    checkOutput("rst_sample_tick", int'(sampleTick), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 'h0400, 1, 0, 0, 2 * DIV);

    randomStimulus(1000);

    applyStimulus(0, 0, 0, 0, 0, 4);
    repeat (2) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/am_modulator.md
AM_MODULATOR -- requirements
Module: am_modulator

Interface
REQ-001 The module SHALL have parameter SAMPLE_DIV, default 64, giving clk cycles per audio sample period (legal 4..65535).
REQ-002 The module SHALL have parameter PHASE_W, default 16, giving the carrier phase accumulator width.
REQ-003 Port clk, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-004 Port RST, input, 1, asynchronous active-high reset.
REQ-005 Port enable, input, 1, modulator run enable.
REQ-006 Port phase_inc, input, PHASE_W, carrier tuning word added to the phase accumulator per cycle.
REQ-007 Port mod_depth, input, 2, modulation depth select.
REQ-008 Port audio_in, input, 8, signed audio sample.
REQ-009 Port audio_valid, input, 1, audio_in valid.
REQ-010 Port audio_ready, output, 1, holding register empty (accepts a sample).
REQ-011 Port rf_out, output, 8, signed registered modulated carrier.
REQ-012 Port sample_tick, output, 1, one-cycle pulse at each sample-period boundary.
REQ-013 Port underrun, output, 1, sticky flag: a sample tick found the holding register empty.

Function
REQ-014 Audio handshake: transfer occurs on a cycle with audio_valid=1 and audio_ready=1; audio_ready SHALL be 1 exactly when the one-entry holding register is empty, independent of audio_valid.
REQ-015 Sample counter SHALL count 0..SAMPLE_DIV-1 while enable=1 and wrap to 0; sample_tick SHALL be 1 in the cycle the counter equals SAMPLE_DIV-1.
REQ-016 On sample_tick with holding full, the held sample SHALL be copied to the active sample register and holding marked empty; a handshake in the same cycle SHALL refill holding (holding ends full).
REQ-017 On sample_tick with holding empty and no same-cycle handshake, active sample SHALL keep its value and underrun SHALL set; underrun clears only on reset.
REQ-018 A same-cycle handshake and empty-holding tick SHALL NOT count as underrun; the new sample goes to holding, not directly to active.
REQ-019 Envelope (9-bit unsigned) env = 128 + (active >>> s), arithmetic shift, s = 3,2,1,0 for mod_depth = 0,1,2,3; range 0..255, no saturation needed.
REQ-020 Phase accumulator SHALL add phase_inc every cycle with enable=1, wrapping modulo 2^PHASE_W; with enable=0 it SHALL be forced to 0.
REQ-021 Carrier (signed 8-bit triangle) from q = phase[MSB:MSB-1], m = phase[MSB-2:MSB-8]: q=0 -> m; q=1 -> 127-m; q=2 -> -m; q=3 -> -(127-m); range -127..127.
REQ-022 Pipeline stage 1 SHALL register carrier and env; stage 2 SHALL register rf_out = (carrier * env) >>> 8, 17-bit signed product, bits [15:8] taken; latency from phase register to rf_out = 2 cycles.
REQ-023 With enable=0 the sample counter SHALL hold at 0, sample_tick=0, stage-1 registers SHALL load 0, and rf_out SHALL reach 0 within 2 cycles; holding register and handshake remain operational.
REQ-024 mod_depth SHALL be sampled combinationally at stage 1; changes take effect 2 cycles later at rf_out without glitching the sample sequence.

Reset
REQ-025 While RST=1: phase, counter, stage registers, active sample = 0; holding empty; audio_ready=1; rf_out=0; sample_tick=0; underrun=0.
REQ-026 RST assertion mid-operation SHALL discard any held sample without an underrun indication; first sample_tick after release occurs SAMPLE_DIV cycles after enable is first seen high.

Verification
REQ-027 Reset, enable=1, no audio, phase_inc=0x0400, SAMPLE_DIV=64 -> rf_out follows 128-amplitude triangle >>>8 (peak 63), period 64 cycles; underrun=1 after first tick.
REQ-028 Stream audio_in=+127 at depth 3 -> env=255, rf_out peak 126/-127; audio_in=-128 -> env=0, rf_out=0.
REQ-029 Push sample while holding full -> audio_ready=0, sample not lost, accepted only after next tick; simultaneous tick+push -> holding remains full, no underrun.
REQ-030 mod_depth sweep 0..3 with audio_in=64 -> env = 136,144,160,192 observed in rf_out peaks 2 cycles after change.
REQ-031 Drop enable mid-stream -> rf_out=0 within 2 cycles, counter and phase at 0; re-enable -> first sample_tick after SAMPLE_DIV cycles.
REQ-032 Assert RST with holding full and rf_out nonzero -> all outputs immediately at reset values, audio_ready=1, underrun=0.
